morse_receiver: RTL and testbench

- Receives Morse code from a single push-button or key line and classifies each press as a dot or a dash by its duration.
- Collects up to 4 elements and closes the letter after an inter-letter gap.
- Reports the captured pattern, then maps it back to a 3-bit letter index for A–H. This is the inverse of the switch-to-Morse letter table used by the transmit path.
- Sits between the board key input and the display/LED logic.

---
 rtl/morse_receiver.sv | 156 +++++++++++++++
 tb/tb_morse_receiver.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/morse_receiver.sv
`default_nettype none
// ============================================================================
// Module   : morse_receiver
// Purpose  : Times key presses as dots or dashes, groups them into letters,
//            and maps a closed letter back to a 3-bit A..H index.
// Revision : 1.0
// ============================================================================
module morse_receiver #(
  parameter int TICKS_PER_UNIT = 25000000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       key_i,
  output logic       valid_o,
  output logic       error_o,
  output logic [2:0] letter_o,
  output logic [3:0] code_o,
  output logic [2:0] size_o,
  output logic       busy_o
);

  localparam int CNT_W = $clog2(3 * TICKS_PER_UNIT + 1);

  localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_dash_min = CNT_W'(2 * TICKS_PER_UNIT);
  localparam logic [CNT_W-1:0] c_gap_last = CNT_W'(3 * TICKS_PER_UNIT - 1);
  localparam logic [CNT_W-1:0] c_cnt_max  = CNT_W'(3 * TICKS_PER_UNIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MARK  = 2'd1,
    S_SPACE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_sync1;
  logic             r_key_s;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_code;
  logic [2:0]       r_count;
  logic             r_ovf;
  logic             r_valid;
  logic             r_error;
  logic [2:0]       r_letter;
  logic [3:0]       r_code_out;
  logic [2:0]       r_size_out;

  logic             w_match;
  logic [2:0]       w_letter;

  // Unused code bits are always zero, so size+code identifies a letter exactly.
  always_comb begin
    w_match  = 1'b1;
    w_letter = 3'd0;
    case ({r_count, r_code})
      {3'd2, 4'b0010}: w_letter = 3'd0;
      {3'd4, 4'b0001}: w_letter = 3'd1;
      {3'd4, 4'b0101}: w_letter = 3'd2;
      {3'd3, 4'b0001}: w_letter = 3'd3;
      {3'd1, 4'b0000}: w_letter = 3'd4;
      {3'd4, 4'b0100}: w_letter = 3'd5;
      {3'd3, 4'b0011}: w_letter = 3'd6;
      {3'd4, 4'b0000}: w_letter = 3'd7;
      default:         w_match  = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_sync1    <= 1'b0;
      r_key_s    <= 1'b0;
      r_cnt      <= '0;
      r_code     <= 4'd0;
      r_count    <= 3'd0;
      r_ovf      <= 1'b0;
      r_valid    <= 1'b0;
      r_error    <= 1'b0;
      r_letter   <= 3'd0;
      r_code_out <= 4'd0;
      r_size_out <= 3'd0;
    end else begin
      r_sync1 <= key_i;
      r_key_s <= r_sync1;
      r_valid <= 1'b0;
      r_error <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (r_key_s) begin
            r_state <= S_MARK;
            r_cnt   <= c_one;
          end
        end

        S_MARK: begin
          if (r_key_s) begin
            if (r_cnt != c_cnt_max) begin
              r_cnt <= r_cnt + c_one;
            end
          end else begin
            if (!r_count[2]) begin
              r_code[r_count[1:0]] <= (r_cnt >= c_dash_min);
              r_count              <= r_count + 3'd1;
            end else begin
              r_ovf <= 1'b1;
            end
            // The release sample itself is the first low sample of the gap.
            r_state <= S_SPACE;
            r_cnt   <= c_one;
          end
        end

        S_SPACE: begin
          if (r_key_s) begin
            r_state <= S_MARK;
            r_cnt   <= c_one;
          end else if (r_cnt >= c_gap_last) begin
            r_cnt   <= c_cnt_max;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + c_one;
          end
        end

        S_DONE: begin
          r_code_out <= r_code;
          r_size_out <= r_count;
          if (!r_ovf && w_match) begin
            r_valid  <= 1'b1;
            r_letter <= w_letter;
          end else begin
            r_error <= 1'b1;
          end
          r_code  <= 4'd0;
          r_count <= 3'd0;
          r_ovf   <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign valid_o  = r_valid;
  assign error_o  = r_error;
  assign letter_o = r_letter;
  assign code_o   = r_code_out;
  assign size_o   = r_size_out;
  assign busy_o   = (r_state == S_MARK) || (r_state == S_SPACE);

endmodule
`default_nettype wire

// File: tb/tb_morse_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_morse_receiver
// Purpose  : Directed self-checking bench for morse_receiver with T = 4.
// Revision : 1.0
// ============================================================================
module tb_morse_receiver;

  logic       clk_i;
  logic       rst_i;
  logic       key_i;
  logic       valid_o;
  logic       error_o;
  logic [2:0] letter_o;
  logic [3:0] code_o;
  logic [2:0] size_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;

  // Pulse capture from the most recent gap
  int         n_pulse, n_valid, n_error, n_both, p_cycle;
  logic       p_valid, p_error, p_busy;
  logic [3:0] p_code;
  logic [2:0] p_size, p_letter;

  morse_receiver #(.TICKS_PER_UNIT(4)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .key_i   (key_i),
    .valid_o (valid_o),
    .error_o (error_o),
    .letter_o(letter_o),
    .code_o  (code_o),
    .size_o  (size_o),
    .busy_o  (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press(input int n);
    key_i = 1'b1;
    repeat (n) @(negedge clk_i);
  endtask

  task automatic gap(input int n);
    key_i   = 1'b0;
    n_pulse = 0; n_valid = 0; n_error = 0; n_both = 0; p_cycle = 0;
    p_valid = 1'b0; p_error = 1'b0; p_busy = 1'b0;
    p_code  = 4'd0; p_size = 3'd0; p_letter = 3'd0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk_i);
      if (valid_o || error_o) begin
        if (n_pulse == 0) begin
          p_cycle = i; p_valid = valid_o; p_error = error_o; p_busy = busy_o;
          p_code = code_o; p_size = size_o; p_letter = letter_o;
        end
        n_pulse++;
        if (valid_o) n_valid++;
        if (error_o) n_error++;
        if (valid_o && error_o) n_both++;
      end
    end
  endtask

  // Release-to-pulse: 2 sync edges + 12 gap samples + 1 DONE edge = 15
  task automatic expect_letter(input string tag, input logic ev, input logic [3:0] ecode,
                               input logic [2:0] esize, input logic [2:0] elet);
    check({tag, "_pulses"}, n_pulse, 1);
    check({tag, "_both"},   n_both, 0);
    check({tag, "_valid"},  p_valid, ev);
    check({tag, "_error"},  p_error, !ev);
    check({tag, "_code"},   p_code, ecode);
    check({tag, "_size"},   p_size, esize);
    check({tag, "_letter"}, p_letter, elet);
    check({tag, "_busy"},   p_busy, 0);
    check({tag, "_lat"},    p_cycle, 15);
  endtask

  initial begin
    int bad;
    rst_i = 1'b1;
    key_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;

    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if ({valid_o, error_o, letter_o, code_o, size_o, busy_o} !== 13'd0) bad++;
    end
    check("reset_quiet", bad, 0);
    check("reset_letter", letter_o, 0);
    check("reset_code", code_o, 0);
    check("reset_size", size_o, 0);

    // A: dot dash
    press(3);
    check("busy_in_mark", busy_o, 1);
    gap(5);
    check("A_intra_nopulse", n_pulse, 0);
    press(10);
    gap(20);
    expect_letter("A", 1'b1, 4'b0010, 3'd2, 3'd0);

    // B: dash dot dot dot
    press(10);
    for (int k = 0; k < 3; k++) begin gap(4); press(3); end
    gap(20);
    expect_letter("B", 1'b1, 4'b0001, 3'd4, 3'd1);

    // First press 7 samples: dot -> H; the 8-sample dash is exercised in G
    press(7);
    for (int k = 0; k < 3; k++) begin gap(4); press(3); end
    gap(20);
    expect_letter("H7", 1'b1, 4'b0000, 3'd4, 3'd7);

    // Single dash is illegal; letter holds H
    press(10);
    gap(20);
    expect_letter("T_err", 1'b0, 4'b0001, 3'd1, 3'd7);

    // Five dots overflow
    press(3);
    for (int k = 0; k < 4; k++) begin gap(4); press(3); end
    gap(20);
    expect_letter("ovf", 1'b0, 4'b0000, 3'd4, 3'd7);

    // Overflow flag must not leak into the next letter
    press(3);
    gap(20);
    expect_letter("E", 1'b1, 4'b0000, 3'd1, 3'd4);

    // Very long hold saturates and still reads as a dash
    press(60);
    gap(20);
    expect_letter("hold", 1'b0, 4'b0001, 3'd1, 3'd4);

    // Reset between 2nd and 3rd element
    press(10); gap(4); press(10); gap(4);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    check("rst_mid_valid", valid_o, 0);
    check("rst_mid_error", error_o, 0);
    check("rst_mid_letter", letter_o, 0);
    check("rst_mid_code", code_o, 0);
    check("rst_mid_size", size_o, 0);
    check("rst_mid_busy", busy_o, 0);
    gap(20);
    check("rst_mid_nopulse", n_pulse, 0);

    // G: dash, 11-cycle gap continues the letter, 8 = dash, 7 = dot
    press(10);
    gap(11);
    check("G_gap11_nopulse", n_pulse, 0);
    press(8);
    gap(4);
    press(7);
    gap(20);
    expect_letter("G", 1'b1, 4'b0011, 3'd3, 3'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
